// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with a DEPTH-entry skid buffer.
// Upstream sees a registered in_ready, so it never waits on a combinational path
// from out_ready. A synchronous flush squashes every held entry. An empty stage
// drives BUBBLE on out_data.
// Ports:
//   CLK, RST             rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready registered)
//   in_data              upstream payload
//   out_valid/out_ready  downstream handshake (out_valid registered)
//   out_data             head payload, BUBBLE while out_valid=0
//   flush                squash all held entries at the next edge
//   count                current occupancy
module pipe_stage_buf #(
  parameter int unsigned       DATA_W = 64,
  parameter int unsigned       DEPTH  = 2,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt, remain;
  logic [DATA_W-1:0] out_data_nxt;
  logic              push, pop, write_en;

  // Pointer advance with explicit wrap; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign write_en = push & ~flush;

  // Next-state: flush wins over any handshake in the same cycle.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    remain       = count;
    out_data_nxt = BUBBLE;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      remain    = count - CNT_W'(pop);
      // Next head is an already-stored entry, or the incoming beat if nothing remains.
      if (remain != '0)  out_data_nxt = mem[rd_ptr_nxt];
      else if (push)     out_data_nxt = in_data;
    end
  end

  // Payload storage; contents only matter while counted as occupied.
  always_ff @(posedge CLK) begin
    if (write_en) mem[wr_ptr] <= in_data;
  end

  // Control and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= BUBBLE;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      in_ready  <= (count_nxt < FULL) | flush;
      out_valid <= (count_nxt != '0);
      out_data  <= out_data_nxt;
    end
  end

endmodule
